// File: rtl/gate_mux_pkg.sv
// Shared definitions for the gates-block exerciser: select codes, widths,
// the FSM state encoding and the golden gate model.
package gate_mux_pkg;

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned ERR_W  = 6;
    localparam int unsigned FAIL_W = 8;

    localparam logic [SEL_W-1:0] SEL_NAND = 3'd0;
    localparam logic [SEL_W-1:0] SEL_AND  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_NOR  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_OR   = 3'd3;
    localparam logic [SEL_W-1:0] SEL_XOR  = 3'd4;
    localparam logic [SEL_W-1:0] SEL_XNOR = 3'd5;
    localparam logic [SEL_W-1:0] SEL_BUF  = 3'd6;
    localparam logic [SEL_W-1:0] SEL_NOT  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Expected output of the gates block; b is ignored for BUF and NOT.
    function automatic logic golden_out(input logic [SEL_W-1:0] sel,
                                        input logic a,
                                        input logic b);
        logic r;
        r = 1'b0;
        case (sel)
            SEL_NAND: r = ~(a & b);
            SEL_AND:  r = a & b;
            SEL_NOR:  r = ~(a | b);
            SEL_OR:   r = a | b;
            SEL_XOR:  r = a ^ b;
            SEL_XNOR: r = ~(a ^ b);
            SEL_BUF:  r = a;
            SEL_NOT:  r = ~a;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_mux_settle_timer.sv
// Loadable down-counter that times the settle window after each new vector.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset (clears the count)
//   load        reload with SETTLE_CYCLES-1
//   dec         decrement by one, stopping at zero
//   is_zero_c   combinational flag: count is zero
module gate_mux_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic is_zero_c
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count register; load takes priority over decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_zero_c = (cnt == '0);

endmodule

// File: rtl/gate_mux_exerciser.sv
// Sweeps all 32 switch vectors into the muxed gates block, samples the LED
// result after a settle window and scores it against the golden model.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   start           begin a sweep (ignored while busy)
//   led_in          result from the gates block under test
//   sw_out          vector to the gates block: [4:2] select, [1] b, [0] a
//   busy            sweep in progress
//   done            sweep finished; held until next start or reset
//   pass            done with zero mismatches (combinational)
//   err_count       number of mismatching vectors
//   fail_vec        bit k set if a vector with select k mismatched
//   first_fail_idx  index of the first mismatching vector
module gate_mux_exerciser
    import gate_mux_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              led_in,
    output logic [IDX_W-1:0]  sw_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [FAIL_W-1:0] fail_vec,
    output logic [IDX_W-1:0]  first_fail_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(31);

    state_t              state, state_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [IDX_W-1:0]    sw_next;
    logic                busy_next, done_next;
    logic [ERR_W-1:0]    err_next;
    logic [FAIL_W-1:0]   fail_next;
    logic [IDX_W-1:0]    ffi_next;
    logic                timer_load, timer_dec, timer_zero;
    logic                mismatch;

    gate_mux_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .dec       (timer_dec),
        .is_zero_c (timer_zero)
    );

    assign mismatch = (led_in != golden_out(idx[4:2], idx[0], idx[1]));

    // State and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            sw_out         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            fail_vec       <= '0;
            first_fail_idx <= '0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            sw_out         <= sw_next;
            busy           <= busy_next;
            done           <= done_next;
            err_count      <= err_next;
            fail_vec       <= fail_next;
            first_fail_idx <= ffi_next;
        end
    end

    // Next-state and next-result logic.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        sw_next    = sw_out;
        busy_next  = busy;
        done_next  = done;
        err_next   = err_count;
        fail_next  = fail_vec;
        ffi_next   = first_fail_idx;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_next   = '0;
                    sw_next    = '0;
                    err_next   = '0;
                    fail_next  = '0;
                    ffi_next   = '0;
                    busy_next  = 1'b1;
                    done_next  = 1'b0;
                    timer_load = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    state_next = ST_SAMPLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_next = err_count + ERR_W'(1);
                    fail_next[idx[4:2]] = 1'b1;
                    if (err_count == '0) begin
                        ffi_next = idx;
                    end
                end
                if (idx == LAST_IDX) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx + IDX_W'(1);
                    sw_next    = idx + IDX_W'(1);
                    timer_load = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pass = done & (err_count == '0);

endmodule
